// File: rtl/types.sv
// Shared types for the RV32I pipeline control slice: data word, register index,
// sequencer state and the per-stage latch control bundle.
package types;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned REG_W = 5;

   typedef logic [XLEN-1:0]  rv32i_word;
   typedef logic [REG_W-1:0] reg_idx_t;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      I_DONE = 2'd1,
      D_DONE = 2'd2
   } ctrl_state_t;

   typedef struct packed {
      logic pc_load;
      logic pc_redirect_sel;
      logic ifid_load;
      logic ifid_flush;
      logic idex_load;
      logic idex_flush;
      logic exmem_load;
      logic memwb_load;
   } stage_ctrl_t;

endpackage

// File: rtl/hazard_unit.sv
// Load-use detector: the ID instruction reads a register that the EX load
// has not yet produced.
module hazard_unit
   import types::*;
(
   input  logic     id_use_rs1_i,
   input  logic     id_use_rs2_i,
   input  reg_idx_t id_rs1_i,
   input  reg_idx_t id_rs2_i,
   input  logic     ex_is_load_i,
   input  reg_idx_t ex_rd_i,
   output logic     load_use_o
);

   logic rs1_hit;
   logic rs2_hit;

   assign rs1_hit    = id_use_rs1_i && (id_rs1_i == ex_rd_i);
   assign rs2_hit    = id_use_rs2_i && (id_rs2_i == ex_rd_i);
   // x0 is never a real dependency
   assign load_use_o = ex_is_load_i && (ex_rd_i != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: joins the I/D cache handshakes,
// buffers the early response, and applies load-use bubbles and EX redirects.
module pipeline_ctrl
   import types::*;
(
   input  logic      clk,
   input  logic      rst,
   input  logic      imem_resp,
   input  rv32i_word imem_rdata,
   output logic      imem_read,
   input  logic      dmem_req,
   input  logic      dmem_resp,
   input  rv32i_word dmem_rdata,
   output logic      dmem_en,
   input  reg_idx_t  id_rs1,
   input  reg_idx_t  id_rs2,
   input  logic      id_use_rs1,
   input  logic      id_use_rs2,
   input  logic      ex_is_load,
   input  reg_idx_t  ex_rd,
   input  logic      ex_redirect,
   output rv32i_word inst_out,
   output rv32i_word dmem_rdata_out,
   output logic      pc_load,
   output logic      ifid_load,
   output logic      idex_load,
   output logic      exmem_load,
   output logic      memwb_load,
   output logic      pc_redirect_sel,
   output logic      ifid_flush,
   output logic      idex_flush,
   output rv32i_word stall_cnt,
   output rv32i_word flush_cnt
);

   ctrl_state_t state_q, state_d;
   rv32i_word   inst_buf_q, inst_buf_d;
   rv32i_word   dbuf_q, dbuf_d;
   rv32i_word   stall_cnt_q, stall_cnt_d;
   rv32i_word   flush_cnt_q, flush_cnt_d;

   logic        i_ok;
   logic        d_ok;
   logic        advance;
   logic        load_use;
   stage_ctrl_t ctrl;

   hazard_unit u_hazard (
      .id_use_rs1_i (id_use_rs1),
      .id_use_rs2_i (id_use_rs2),
      .id_rs1_i     (id_rs1),
      .id_rs2_i     (id_rs2),
      .ex_is_load_i (ex_is_load),
      .ex_rd_i      (ex_rd),
      .load_use_o   (load_use)
   );

   assign i_ok    = imem_resp || (state_q == I_DONE);
   assign d_ok    = !dmem_req || dmem_resp || (state_q == D_DONE);
   assign advance = i_ok && d_ok;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= RUN;
         inst_buf_q  <= '0;
         dbuf_q      <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         inst_buf_q  <= inst_buf_d;
         dbuf_q      <= dbuf_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // Next state: park whichever response arrives first until the other one lands
   always_comb begin
      state_d     = state_q;
      inst_buf_d  = inst_buf_q;
      dbuf_d      = dbuf_q;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      case (state_q)
         RUN: begin
            if (imem_resp && !d_ok) begin
               state_d    = I_DONE;
               inst_buf_d = imem_rdata;
            end else if (dmem_resp && !i_ok) begin
               state_d = D_DONE;
               dbuf_d  = dmem_rdata;
            end
         end
         I_DONE, D_DONE: begin
            if (advance) state_d = RUN;
         end
         default: state_d = RUN;
      endcase
      if (!advance) stall_cnt_d = stall_cnt_q + 32'(1);
      if (advance && ex_redirect) flush_cnt_d = flush_cnt_q + 32'(1);
   end

   // Latch controls: redirect beats load-use; everything holds on a stall or reset
   always_comb begin
      ctrl = '0;
      if (advance && !rst) begin
         ctrl.exmem_load = 1'b1;
         ctrl.memwb_load = 1'b1;
         ctrl.idex_load  = 1'b1;
         if (ex_redirect) begin
            ctrl.pc_load         = 1'b1;
            ctrl.pc_redirect_sel = 1'b1;
            ctrl.ifid_load       = 1'b1;
            ctrl.ifid_flush      = 1'b1;
            ctrl.idex_flush      = 1'b1;
         end else if (load_use) begin
            ctrl.idex_flush = 1'b1;
         end else begin
            ctrl.pc_load   = 1'b1;
            ctrl.ifid_load = 1'b1;
         end
      end
   end

   assign pc_load         = ctrl.pc_load;
   assign pc_redirect_sel = ctrl.pc_redirect_sel;
   assign ifid_load       = ctrl.ifid_load;
   assign ifid_flush      = ctrl.ifid_flush;
   assign idex_load       = ctrl.idex_load;
   assign idex_flush      = ctrl.idex_flush;
   assign exmem_load      = ctrl.exmem_load;
   assign memwb_load      = ctrl.memwb_load;

   assign imem_read = !rst && (state_q != I_DONE);
   assign dmem_en   = !rst && dmem_req && (state_q != D_DONE);

   assign inst_out       = rst ? '0 : ((state_q == I_DONE) ? inst_buf_q : imem_rdata);
   assign dmem_rdata_out = rst ? '0 : ((state_q == D_DONE) ? dbuf_q : dmem_rdata);

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: cache handshake joins, response buffering,
// load-use bubbles, redirects and reset during a stall.
module tb_pipeline_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_resp;
   logic [31:0] imem_rdata;
   logic        imem_read;
   logic        dmem_req;
   logic        dmem_resp;
   logic [31:0] dmem_rdata;
   logic        dmem_en;
   logic [4:0]  id_rs1;
   logic [4:0]  id_rs2;
   logic        id_use_rs1;
   logic        id_use_rs2;
   logic        ex_is_load;
   logic [4:0]  ex_rd;
   logic        ex_redirect;
   logic [31:0] inst_out;
   logic [31:0] dmem_rdata_out;
   logic        pc_load;
   logic        ifid_load;
   logic        idex_load;
   logic        exmem_load;
   logic        memwb_load;
   logic        pc_redirect_sel;
   logic        ifid_flush;
   logic        idex_flush;
   logic [31:0] stall_cnt;
   logic [31:0] flush_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pipeline_ctrl dut (
      .clk             (clk),
      .rst             (rst),
      .imem_resp       (imem_resp),
      .imem_rdata      (imem_rdata),
      .imem_read       (imem_read),
      .dmem_req        (dmem_req),
      .dmem_resp       (dmem_resp),
      .dmem_rdata      (dmem_rdata),
      .dmem_en         (dmem_en),
      .id_rs1          (id_rs1),
      .id_rs2          (id_rs2),
      .id_use_rs1      (id_use_rs1),
      .id_use_rs2      (id_use_rs2),
      .ex_is_load      (ex_is_load),
      .ex_rd           (ex_rd),
      .ex_redirect     (ex_redirect),
      .inst_out        (inst_out),
      .dmem_rdata_out  (dmem_rdata_out),
      .pc_load         (pc_load),
      .ifid_load       (ifid_load),
      .idex_load       (idex_load),
      .exmem_load      (exmem_load),
      .memwb_load      (memwb_load),
      .pc_redirect_sel (pc_redirect_sel),
      .ifid_flush      (ifid_flush),
      .idex_flush      (idex_flush),
      .stall_cnt       (stall_cnt),
      .flush_cnt       (flush_cnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Pack latch controls as {pc,sel,ifid,ifid_fl,idex,idex_fl,exmem,memwb}
   function automatic logic [31:0] ctl();
      return 32'({pc_load, pc_redirect_sel, ifid_load, ifid_flush,
                  idex_load, idex_flush, exmem_load, memwb_load});
   endfunction

   localparam logic [31:0] C_NONE  = 32'h00;
   localparam logic [31:0] C_ALL   = 32'hAB; // 1010_1011
   localparam logic [31:0] C_LU    = 32'h0F; // 0000_1111
   localparam logic [31:0] C_REDIR = 32'hFF;

   task automatic caches(input logic ir, input logic [31:0] ird, input logic dq,
                         input logic dr, input logic [31:0] drd);
      imem_resp  = ir;
      imem_rdata = ird;
      dmem_req   = dq;
      dmem_resp  = dr;
      dmem_rdata = drd;
   endtask

   initial begin
      rst = 1'b1;
      caches(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
      ex_is_load = 1'b0; ex_rd = '0; ex_redirect = 1'b0;
      @(negedge clk);
      @(negedge clk);

      // Reset mid-D_DONE
      rst = 1'b0;
      caches(1'b0, 32'h0, 1'b1, 1'b1, 32'hDEADBEEF);
      #1 check("dresp_stall_ctl", ctl(), C_NONE);
      @(negedge clk);
      caches(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      #1 check("ddone_en", 32'(dmem_en), 32'h0);
      check("ddone_buf", dmem_rdata_out, 32'hDEADBEEF);
      check("ddone_stall_cnt", stall_cnt, 32'd1);
      imem_rdata = 32'h11111111;
      rst = 1'b1;
      #1 check("rst_ctl", ctl(), C_NONE);
      check("rst_en", 32'({imem_read, dmem_en}), 32'h0);
      check("rst_inst", inst_out, 32'h0);
      check("rst_dout", dmem_rdata_out, 32'h0);
      check("rst_stall_cnt", stall_cnt, 32'h0);
      check("rst_flush_cnt", flush_cnt, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      caches(1'b1, 32'h22222222, 1'b1, 1'b1, 32'hAAAA5555);
      #1 check("post_rst_den", 32'(dmem_en), 32'h1);
      check("post_rst_dout", dmem_rdata_out, 32'hAAAA5555);
      check("post_rst_ctl", ctl(), C_ALL);
      @(negedge clk);

      // Ten single-cycle hits on both ports
      for (int i = 0; i < 10; i++) begin
         caches(1'b1, 32'(i), 1'b1, 1'b1, 32'(i + 100));
         #1 check("hit_ctl", ctl(), C_ALL);
         check("hit_iread", 32'(imem_read), 32'h1);
         check("hit_inst", inst_out, 32'(i));
         @(negedge clk);
      end
      check("hit_stall_cnt", stall_cnt, 32'h0);

      // D response at cycle 2, I response at cycle 5
      caches(1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
      #1 check("seq_c0", ctl(), C_ALL);
      @(negedge clk);
      #1 check("seq_c1", ctl(), C_ALL);
      @(negedge clk);
      caches(1'b0, 32'h0, 1'b1, 1'b1, 32'h12345678);
      #1 check("seq_c2_ctl", ctl(), C_NONE);
      check("seq_c2_den", 32'(dmem_en), 32'h1);
      @(negedge clk);
      for (int c = 3; c <= 4; c++) begin
         caches(1'b0, 32'h0, 1'b1, 1'b0, 32'hFFFFFFFF);
         #1 check("seq_wait_den", 32'(dmem_en), 32'h0);
         check("seq_wait_ctl", ctl(), C_NONE);
         check("seq_wait_iread", 32'(imem_read), 32'h1);
         check("seq_wait_dout", dmem_rdata_out, 32'h12345678);
         @(negedge clk);
      end
      caches(1'b1, 32'h00A00093, 1'b1, 1'b0, 32'hFFFFFFFF);
      #1 check("seq_c5_den", 32'(dmem_en), 32'h0);
      check("seq_c5_ctl", ctl(), C_ALL);
      check("seq_c5_dout", dmem_rdata_out, 32'h12345678);
      check("seq_c5_inst", inst_out, 32'h00A00093);
      @(negedge clk);
      check("seq_stall_cnt", stall_cnt, 32'd3);
      caches(1'b1, 32'h0, 1'b1, 1'b1, 32'h0BADF00D);
      #1 check("seq_reassert_den", 32'(dmem_en), 32'h1);
      check("seq_reassert_dout", dmem_rdata_out, 32'h0BADF00D);
      @(negedge clk);

      // Load-use on rs2, then the dependent instruction advances
      caches(1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
      ex_is_load = 1'b1; ex_rd = 5'd5; id_use_rs2 = 1'b1; id_rs2 = 5'd5;
      #1 check("lu_ctl", ctl(), C_LU);
      @(negedge clk);
      ex_is_load = 1'b0;
      #1 check("lu_after_ctl", ctl(), C_ALL);
      @(negedge clk);
      ex_is_load = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0;
      #1 check("lu_x0_ctl", ctl(), C_ALL);
      ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b0;
      #1 check("lu_unused_ctl", ctl(), C_ALL);
      id_use_rs1 = 1'b1; id_rs1 = 5'd5;
      #1 check("lu_rs1_ctl", ctl(), C_LU);
      @(negedge clk);

      // Redirect together with load-use
      ex_redirect = 1'b1;
      #1 check("redir_lu_ctl", ctl(), C_REDIR);
      @(negedge clk);
      check("redir_flush_cnt", flush_cnt, 32'd1);
      check("redir_stall_cnt", stall_cnt, 32'd3);
      ex_is_load = 1'b0; id_use_rs1 = 1'b0;

      // Redirect held while the I-cache stalls four cycles
      caches(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      for (int c = 0; c < 4; c++) begin
         #1 check("redir_wait_ctl", ctl(), C_NONE);
         check("redir_wait_iread", 32'(imem_read), 32'h1);
         @(negedge clk);
      end
      check("redir_wait_flush_cnt", flush_cnt, 32'd1);
      imem_resp = 1'b1;
      #1 check("redir_resp_ctl", ctl(), C_REDIR);
      @(negedge clk);
      check("redir2_flush_cnt", flush_cnt, 32'd2);
      check("redir2_stall_cnt", stall_cnt, 32'd7);
      ex_redirect = 1'b0;

      // I response first: buffered and not re-requested until the D side lands
      caches(1'b1, 32'h00000013, 1'b1, 1'b0, 32'h0);
      #1 check("idone_c0_ctl", ctl(), C_NONE);
      @(negedge clk);
      caches(1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h0);
      #1 check("idone_iread", 32'(imem_read), 32'h0);
      check("idone_inst", inst_out, 32'h00000013);
      check("idone_ctl", ctl(), C_NONE);
      @(negedge clk);
      caches(1'b0, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h00000055);
      #1 check("idone_adv_ctl", ctl(), C_ALL);
      check("idone_adv_inst", inst_out, 32'h00000013);
      check("idone_adv_dout", dmem_rdata_out, 32'h00000055);
      @(negedge clk);
      caches(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      #1 check("idone_reassert", 32'(imem_read), 32'h1);
      check("idone_stall_cnt", stall_cnt, 32'd9);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
